// File: rtl/tc_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tc_pkg : mode encodings and one-hot helper for tc_scan_decoder           |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package tc_pkg;

  typedef enum logic [1:0] {
    MODE_DIRECT = 2'b00,
    MODE_SCAN   = 2'b01,
    MODE_HOLD   = 2'b10
  } tc_mode_e;

  // Widest decoder this helper serves; callers truncate to their OUT_N.
  localparam int MAX_SEL_W = 8;
  localparam int MAX_OUT_N = 2 ** MAX_SEL_W;

  function automatic logic [MAX_OUT_N-1:0] onehot(input logic [31:0] sel_v);
    onehot = MAX_OUT_N'(1) << sel_v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/tc_dwell_counter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tc_dwell_counter : dwell counter with clear/enable and advance strobe    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tc_dwell_counter #(
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr_i,
  input  logic               en_i,
  input  logic [DWELL_W-1:0] dwell_i,
  output logic               adv_o
);

  logic [DWELL_W-1:0] cnt_q, cnt_d;

  // Strobe is unqualified by en_i so the parent can gate it without a loop.
  assign adv_o = (cnt_q == dwell_i);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = adv_o ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/tc_scan_decoder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tc_scan_decoder : registered one-hot decoder with direct/scan/hold modes |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tc_scan_decoder
  import tc_pkg::*;
#(
  parameter int SEL_W   = 3,
  parameter int OUT_N   = 2 ** SEL_W,
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               dis,
  input  logic [1:0]         mode,
  input  logic [SEL_W-1:0]   sel,
  input  logic               load,
  input  logic [DWELL_W-1:0] dwell,
  output logic [OUT_N-1:0]   out,
  output logic [SEL_W-1:0]   idx,
  output logic               wrap
);

  tc_mode_e           mode_q, mode_d, mode_eff;
  logic [SEL_W-1:0]   idx_q, idx_d;
  logic [OUT_N-1:0]   out_q, out_d;
  logic               wrap_q, wrap_d;
  logic               cnt_clr, cnt_en, cnt_adv;

  tc_dwell_counter #(
    .DWELL_W (DWELL_W)
  ) u_dwell (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_i   (cnt_clr),
    .en_i    (cnt_en),
    .dwell_i (dwell),
    .adv_o   (cnt_adv)
  );

  always_comb begin
    case (mode)
      2'b00:   mode_eff = MODE_DIRECT;
      2'b01:   mode_eff = MODE_SCAN;
      default: mode_eff = MODE_HOLD;
    endcase
  end

  always_comb begin
    mode_d  = mode_q;
    idx_d   = idx_q;
    wrap_d  = 1'b0;
    cnt_clr = 1'b0;
    cnt_en  = 1'b0;
    if (!dis) begin
      mode_d = mode_eff;
      case (mode_eff)
        MODE_DIRECT: begin
          idx_d   = sel;
          cnt_clr = 1'b1;
        end
        MODE_SCAN: begin
          if (load) begin
            idx_d   = sel;
            cnt_clr = 1'b1;
          end else if (mode_q != MODE_SCAN) begin
            // Entry keeps idx so the sweep resumes from the last output.
            cnt_clr = 1'b1;
          end else begin
            cnt_en = 1'b1;
            if (cnt_adv) begin
              idx_d  = idx_q + 1'b1;
              wrap_d = &idx_q;
            end
          end
        end
        default: ;
      endcase
    end
    // Deriving out from idx_d keeps out == onehot(idx) whenever enabled.
    out_d = dis ? '0 : OUT_N'(onehot(32'(idx_d)));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q <= MODE_HOLD;
      idx_q  <= '0;
      out_q  <= '0;
      wrap_q <= 1'b0;
    end else begin
      mode_q <= mode_d;
      idx_q  <= idx_d;
      out_q  <= out_d;
      wrap_q <= wrap_d;
    end
  end

  assign out  = out_q;
  assign idx  = idx_q;
  assign wrap = wrap_q;

endmodule
`default_nettype wire

// File: tb/tb_tc_scan_decoder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_tc_scan_decoder : directed vector bench for tc_scan_decoder           |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_tc_scan_decoder;

  localparam int SEL_W   = 3;
  localparam int OUT_N   = 8;
  localparam int DWELL_W = 8;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               dis = 1'b0;
  logic [1:0]         mode = 2'b00;
  logic [SEL_W-1:0]   sel = '0;
  logic               load = 1'b0;
  logic [DWELL_W-1:0] dwell = '0;
  logic [OUT_N-1:0]   out;
  logic [SEL_W-1:0]   idx;
  logic               wrap;

  int n_chk  = 0;
  int n_pass = 0;

  typedef struct {
    logic             dis;
    logic [1:0]       mode;
    logic [SEL_W-1:0] sel;
    logic             load;
    logic [7:0]       dwell;
    logic [7:0]       e_out;
    logic [2:0]       e_idx;
    logic             e_wrap;
  } vec_t;

  vec_t vq[$];

  tc_scan_decoder #(
    .SEL_W   (SEL_W),
    .OUT_N   (OUT_N),
    .DWELL_W (DWELL_W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .dis   (dis),
    .mode  (mode),
    .sel   (sel),
    .load  (load),
    .dwell (dwell),
    .out   (out),
    .idx   (idx),
    .wrap  (wrap)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic chk_all(input string name, input logic [7:0] e_out,
                         input logic [2:0] e_idx, input logic e_wrap);
    chk({name, ".out"},  32'(out),  32'(e_out));
    chk({name, ".idx"},  32'(idx),  32'(e_idx));
    chk({name, ".wrap"}, 32'(wrap), 32'(e_wrap));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // dis, mode, sel, load, dwell, exp out, exp idx, exp wrap
    vq.push_back('{1'b0, 2'b00, 3'd5, 1'b0, 8'd0, 8'h20, 3'd5, 1'b0});
    vq.push_back('{1'b0, 2'b00, 3'd2, 1'b0, 8'd0, 8'h04, 3'd2, 1'b0});
    vq.push_back('{1'b1, 2'b00, 3'd2, 1'b0, 8'd0, 8'h00, 3'd2, 1'b0});
    vq.push_back('{1'b1, 2'b00, 3'd2, 1'b0, 8'd0, 8'h00, 3'd2, 1'b0});
    vq.push_back('{1'b1, 2'b00, 3'd2, 1'b0, 8'd0, 8'h00, 3'd2, 1'b0});
    vq.push_back('{1'b0, 2'b00, 3'd2, 1'b0, 8'd0, 8'h04, 3'd2, 1'b0});
    vq.push_back('{1'b0, 2'b00, 3'd6, 1'b0, 8'd0, 8'h40, 3'd6, 1'b0});
    vq.push_back('{1'b0, 2'b01, 3'd0, 1'b0, 8'd2, 8'h40, 3'd6, 1'b0});
    vq.push_back('{1'b0, 2'b01, 3'd0, 1'b0, 8'd2, 8'h40, 3'd6, 1'b0});
    vq.push_back('{1'b0, 2'b01, 3'd0, 1'b0, 8'd2, 8'h40, 3'd6, 1'b0});
    vq.push_back('{1'b0, 2'b01, 3'd0, 1'b0, 8'd2, 8'h80, 3'd7, 1'b0});
    vq.push_back('{1'b0, 2'b01, 3'd0, 1'b0, 8'd2, 8'h80, 3'd7, 1'b0});
    vq.push_back('{1'b0, 2'b01, 3'd0, 1'b0, 8'd2, 8'h80, 3'd7, 1'b0});
    vq.push_back('{1'b0, 2'b01, 3'd0, 1'b0, 8'd2, 8'h01, 3'd0, 1'b1});

    // Reset: outputs stay zero while rst_n is low, even with DIRECT sel=5.
    mode = 2'b00;
    sel  = 3'd5;
    tick();
    chk_all("reset0", 8'h00, 3'd0, 1'b0);
    tick();
    chk_all("reset1", 8'h00, 3'd0, 1'b0);
    rst_n = 1'b1;

    foreach (vq[i]) begin
      dis   = vq[i].dis;
      mode  = vq[i].mode;
      sel   = vq[i].sel;
      load  = vq[i].load;
      dwell = vq[i].dwell;
      tick();
      chk_all($sformatf("vec%0d", i), vq[i].e_out, vq[i].e_idx, vq[i].e_wrap);
    end

    // dwell=0 sweep from idx 0: two full passes, wrap on each return to 0.
    begin
      int wraps = 0;
      dwell = 8'd0;
      for (int k = 1; k <= 16; k++) begin
        logic [2:0] ei;
        ei = 3'(k);
        tick();
        chk_all($sformatf("sweep%0d", k), 8'(1 << ei), ei, (ei == 3'd0));
        if (wrap) wraps++;
      end
      chk("sweep.wraps", 32'(wraps), 32'd2);
    end

    // HOLD (both encodings) freezes at idx 0.
    mode = 2'b10;
    tick();
    chk_all("hold0", 8'h01, 3'd0, 1'b0);
    tick();
    chk_all("hold1", 8'h01, 3'd0, 1'b0);
    mode = 2'b11;
    tick();
    chk_all("hold11", 8'h01, 3'd0, 1'b0);

    // Load on the cycle cnt==dwell beats the advance.
    mode  = 2'b01;
    dwell = 8'd5;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk_all($sformatf("ld_pre%0d", k), 8'h01, 3'd0, 1'b0);
    end
    load = 1'b1;
    sel  = 3'd3;
    tick();
    load = 1'b0;
    sel  = 3'd0;
    chk_all("ld0", 8'h08, 3'd3, 1'b0);
    for (int k = 1; k < 6; k++) begin
      tick();
      chk_all($sformatf("ld%0d", k), 8'h08, 3'd3, 1'b0);
    end
    tick();
    chk_all("ld_adv", 8'h10, 3'd4, 1'b0);

    // Asynchronous reset between edges.
    tick();
    rst_n = 1'b0;
    #1;
    chk_all("arst", 8'h00, 3'd0, 1'b0);
    tick();
    dwell = 8'd0;
    mode  = 2'b01;
    rst_n = 1'b1;
    tick();
    chk_all("arst_entry", 8'h01, 3'd0, 1'b0);
    tick();
    chk_all("arst_adv", 8'h02, 3'd1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/tc_scan_decoder.md
Name: tc_scan_decoder

Overview:
Parametrised, registered one-hot decoder. Maps a SEL_W-bit index onto 2**SEL_W one-hot outputs, with a global disable.
- Adds an auto-scan mode: an internal index steps through all outputs, holding each for a programmable dwell time.
- Adds a hold mode that freezes the current output.
- Used as a column/row strobe generator and channel sequencer in the component library. Sits between control logic and per-channel enables.

Parameters:
- SEL_W, 3, select/index width; must be >= 1.
- OUT_N, 2**SEL_W, number of one-hot outputs; derived, never overridden.
- DWELL_W, 8, width of the dwell-count input and the internal dwell counter.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- dis  input  1  disable; forces out to all-zero.
- mode  input  2  operating mode: 00 DIRECT, 01 SCAN, 10 HOLD, 11 treated as HOLD.
- sel  input  SEL_W  index used in DIRECT mode; load value in SCAN mode.
- load  input  1  SCAN only: loads sel into the index and clears the dwell counter.
- dwell  input  DWELL_W  extra cycles each output stays active in SCAN (0 = advance every cycle).
- out  output  OUT_N  registered one-hot (or all-zero) output.
- idx  output  SEL_W  registered current index.
- wrap  output  1  one-cycle pulse when the SCAN index advances from OUT_N-1 to 0.

Behaviour:
- Reset (rst_n low, asynchronous): out=0, idx=0, wrap=0, dwell counter cnt=0, state register=HOLD. All outputs stay at these values until the first rising clk edge after rst_n is released. Reset asserted mid-scan clears everything immediately, without waiting for a clock edge.
- Every output is registered. Latency from any input change to out/idx/wrap is 1 cycle.
- Invariant: whenever dis=0 and rst_n has been released, out == onehot(idx) on the same cycle.
- Priority, highest first: reset > dis > mode.
- dis=1: next out=0 and wrap=0. idx, cnt and the state register hold their values. On the cycle after dis falls, behaviour resumes from the held idx/cnt.
- The state register records the mode applied on the previous cycle. It is used to detect entry into SCAN. It updates only when dis=0.
- DIRECT:
  - idx<=sel, out<=onehot(sel), cnt<=0, wrap<=0.
  - load is ignored.
- SCAN:
  - Entry (previous state != SCAN): cnt<=0. idx keeps its current value, so the scan starts from the last selected output. out<=onehot(idx).
  - load=1: idx<=sel, cnt<=0, wrap<=0. Load takes priority over advance on the same cycle.
  - Otherwise, if cnt==dwell: idx<=idx+1 mod OUT_N, cnt<=0. wrap<=1 iff the old idx was OUT_N-1.
  - Otherwise: cnt<=cnt+1, wrap<=0.
  - Resulting period: each output is active for dwell+1 cycles; a full sweep takes OUT_N*(dwell+1) cycles.
  - dwell changed mid-dwell: takes effect at the next comparison. If the new dwell is below cnt, cnt keeps incrementing and wraps at 2**DWELL_W before matching. This is accepted behaviour.
- HOLD (mode 10 or 11): idx, cnt and out are frozen; wrap<=0.
- Arithmetic: idx increment is modulo OUT_N (natural SEL_W overflow). cnt is unsigned DWELL_W wide, and the compare is exact equality.
- SEL_W=1 is a legal case: 2 outputs, and wrap pulses on every second advance.

Decomposition:
- Shared package tc_pkg:
  - mode encodings MODE_DIRECT=2'b00, MODE_SCAN=2'b01, MODE_HOLD=2'b10;
  - function onehot(sel) returning an OUT_N-bit vector.
- One natural sub-module: tc_dwell_counter. It holds cnt, compares against dwell, handles clear/enable, and outputs an advance strobe.
- Top level contains the mode state register, the idx register, and the out/wrap registers.

Test Plan (SEL_W=3, DWELL_W=8):
- Reset/direct: rst_n low, then high; mode=DIRECT, sel=5 -> out stays 8'h00 through reset; one cycle after the first edge, out=8'h20 and idx=5.
- Disable: in DIRECT with sel=2, pulse dis for 3 cycles -> out=8'h00 one cycle after dis rises; out=8'h04 one cycle after dis falls; idx stays 2 throughout.
- Scan with dwell=2 from idx=6 -> out is 8'h40 for 3 cycles, then 8'h80 for 3 cycles, then 8'h01. wrap=1 exactly on the cycle out first shows 8'h01.
- Scan with dwell=0 for 16 cycles -> idx steps 0..7 twice, and wrap pulses exactly twice. Then mode=HOLD -> out frozen at its current value with wrap=0.
- Load mid-dwell: in SCAN with dwell=5, assert load with sel=3 on the same cycle cnt==dwell -> idx=3 (not the old idx+1), cnt restarts, and out=8'h08 holds for 6 cycles.
- Async reset mid-scan: drop rst_n between clock edges -> out=0, idx=0 and wrap=0 before the next edge. After release with mode=SCAN and dwell=0, the first advance is to idx=1.
